// File: rtl/pkt_operand_driver.sv
// rtl/pkt_operand_driver.sv - packet-to-transaction operand driver with in-order result capture
// Splits one packed payload into operand beats and gathers the DUT results into a packed vector.
module pkt_operand_driver #(
  parameter int OP_WIDTH  = 8,
  parameter int NUM_OPS   = 2,
  parameter int NUM_TXN   = 100,
  parameter int RES_WIDTH = 8,
  localparam int TXN_W    = NUM_OPS * OP_WIDTH,
  localparam int PKT_W    = NUM_TXN * TXN_W,
  localparam int CNT_W    = $clog2(NUM_TXN + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pkt_valid,
  output logic                           pkt_ready,
  input  logic [PKT_W-1:0]               pkt_data,
  input  logic [CNT_W-1:0]               pkt_len,
  output logic                           op_valid,
  input  logic                           op_ready,
  output logic [TXN_W-1:0]               op_data,
  input  logic                           res_valid,
  input  logic [RES_WIDTH-1:0]           res_data,
  output logic [NUM_TXN*RES_WIDTH-1:0]   res_pkt,
  output logic                           done,
  output logic                           res_ovf
);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [PKT_W-1:0]             shift_q, shift_d;
  logic [CNT_W-1:0]             len_q, len_d;
  logic [CNT_W-1:0]             issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]             res_cnt_q, res_cnt_d;
  logic [NUM_TXN*RES_WIDTH-1:0] res_pkt_q, res_pkt_d;
  logic                         res_ovf_q, res_ovf_d;

  logic             accept;
  logic             issue_hs;
  logic             last_issue;
  logic             res_take;
  logic [CNT_W-1:0] res_cnt_inc;

  assign accept      = pkt_valid && (state_q == IDLE);
  assign issue_hs    = (state_q == SEND) && op_ready;
  assign last_issue  = issue_hs && ((issue_cnt_q + CNT_W'(1)) == len_q);
  // A result is only taken while a packet is live and still owes results.
  assign res_take    = res_valid && ((state_q == SEND) || (state_q == DRAIN)) && (res_cnt_q < len_q);
  assign res_cnt_inc = res_cnt_q + CNT_W'(res_take);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SEND;
      SEND:  if (last_issue) state_d = (res_cnt_inc == len_q) ? DONE : DRAIN;
      DRAIN: if (res_cnt_inc == len_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_ready = (state_q == IDLE);
    op_valid  = (state_q == SEND);
    done      = (state_q == DONE);
    op_data   = shift_q[TXN_W-1:0];
    res_pkt   = res_pkt_q;
    res_ovf   = res_ovf_q;
  end

  always_comb begin
    shift_d     = shift_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    res_pkt_d   = res_pkt_q;
    res_ovf_d   = res_ovf_q;
    if (accept) begin
      shift_d     = pkt_data;
      len_d       = ((pkt_len == '0) || (pkt_len > CNT_W'(NUM_TXN))) ? CNT_W'(NUM_TXN) : pkt_len;
      issue_cnt_d = '0;
      res_cnt_d   = '0;
      res_pkt_d   = '0;
      res_ovf_d   = 1'b0;
    end
    if (issue_hs) begin
      shift_d     = shift_q >> TXN_W;
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    if (res_take) begin
      res_pkt_d[int'(res_cnt_q) * RES_WIDTH +: RES_WIDTH] = res_data;
      res_cnt_d = res_cnt_inc;
    end
    if (res_valid && !res_take) begin
      res_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      res_pkt_q   <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      res_pkt_q   <= res_pkt_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

endmodule

// File: tb/tb_pkt_operand_driver.sv
// tb/tb_pkt_operand_driver.sv - self-checking bench for pkt_operand_driver
// Directed vector table plus randomized packets against a loopback-adder reference model.
module tb_pkt_operand_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [63:0] pkt_data;
  logic [2:0]  pkt_len;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_data;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [31:0] res_pkt;
  logic        done;
  logic        res_ovf;

  int passed = 0;
  int total  = 0;

  pkt_operand_driver #(
    .OP_WIDTH(8), .NUM_OPS(2), .NUM_TXN(4), .RES_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_len(pkt_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_data(res_data),
    .res_pkt(res_pkt), .done(done), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] data;
    int          len;
    int          mode;   // 0: op_ready high, 1: alternating from 0, 2: random
    int          lat;
    logic [31:0] exp_res;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];
  int   due_q[$];
  logic [7:0] sum_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int len);
    return (len == 0 || len > 4) ? 4 : len;
  endfunction

  // Expected result vector: per-transaction operand sums, unused slices zero.
  function automatic logic [31:0] model_res(input logic [63:0] d, input int len);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < eff_len(len); i++)
      r[i*8 +: 8] = d[i*16 +: 8] + d[i*16+8 +: 8];
    return r;
  endfunction

  task automatic run_packet(input string nm, input logic [63:0] d, input int len, input int mode,
                            input int lat, input logic [31:0] exp_res, input int exp_n);
    int k, it, done_cnt, done_cyc, last_res, n_iss, seq_bad, rdy_bad, stab_bad;
    logic prev_stall;
    logic [15:0] prev_data;
    logic [7:0] s;
    done_cnt = 0; done_cyc = -1; last_res = -10; n_iss = 0;
    seq_bad = 0; rdy_bad = 0; stab_bad = 0; prev_stall = 1'b0; prev_data = '0;
    it = 0;
    while (!pkt_ready && it < 50) begin tick(); it++; end
    check({nm, ".ready_before"}, pkt_ready, 1);
    pkt_valid = 1'b1; pkt_data = d; pkt_len = 3'(len); res_valid = 1'b0; op_ready = 1'b0;
    tick();
    pkt_valid = 1'b0;
    check({nm, ".ovf_clear"}, res_ovf, 0);
    check({nm, ".res_clear"}, res_pkt, 0);
    due_q.delete(); sum_q.delete();
    for (k = 0; k < 400; k++) begin
      if (done) begin done_cnt++; done_cyc = k; end
      else if (done_cnt > 0) break;
      else if (pkt_ready) rdy_bad++;
      if (prev_stall && (!op_valid || op_data !== prev_data)) stab_bad++;
      op_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 1) : 1'($urandom_range(0, 1));
      res_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= k) begin
        res_valid = 1'b1; res_data = sum_q[0];
        void'(due_q.pop_front()); void'(sum_q.pop_front());
        last_res = k;
      end
      if (op_valid && op_ready) begin
        if (n_iss >= 4 || op_data !== d[n_iss*16 +: 16]) seq_bad++;
        s = op_data[7:0] + op_data[15:8];
        due_q.push_back(k + lat); sum_q.push_back(s);
        n_iss++;
      end
      prev_stall = op_valid && !op_ready;
      prev_data  = op_data;
      tick();
    end
    res_valid = 1'b0; op_ready = 1'b0;
    if (k >= 400) check({nm, ".timeout"}, 0, 1);
    check({nm, ".issued"}, n_iss, exp_n);
    check({nm, ".op_seq"}, seq_bad, 0);
    check({nm, ".stable"}, stab_bad, 0);
    check({nm, ".res_pkt"}, res_pkt, exp_res);
    check({nm, ".done_cnt"}, done_cnt, 1);
    check({nm, ".done_after_res"}, done_cyc, last_res + 1);
    check({nm, ".busy_not_ready"}, rdy_bad, 0);
    check({nm, ".ovf"}, res_ovf, 0);
    check({nm, ".ready_after"}, pkt_ready, 1);
  endtask

  initial begin
    logic [63:0] rd;
    int rl;
    vecs[0] = '{"basic",   64'h0807_0605_0403_0201, 4, 0, 1, 32'h0F0B_0703, 4};
    vecs[1] = '{"bp",      64'h0807_0605_0403_0201, 4, 1, 1, 32'h0F0B_0703, 4};
    vecs[2] = '{"len2",    64'h0807_0605_0403_0201, 2, 0, 1, 32'h0000_0703, 2};
    vecs[3] = '{"len0",    64'h0807_0605_0403_0201, 0, 0, 1, 32'h0F0B_0703, 4};
    vecs[4] = '{"len7",    64'h0807_0605_0403_0201, 7, 0, 1, 32'h0F0B_0703, 4};
    vecs[5] = '{"slow",    64'h0807_0605_0403_0201, 4, 0, 5, 32'h0F0B_0703, 4};

    reset = 1'b1; pkt_valid = 1'b0; pkt_data = '0; pkt_len = '0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst.pkt_ready", pkt_ready, 1);
    check("rst.op_valid", op_valid, 0);
    check("rst.op_data", op_data, 0);
    check("rst.res_pkt", res_pkt, 0);
    check("rst.done", done, 0);
    check("rst.res_ovf", res_ovf, 0);

    for (int i = 0; i < 6; i++)
      run_packet(vecs[i].name, vecs[i].data, vecs[i].len, vecs[i].mode, vecs[i].lat,
                 vecs[i].exp_res, vecs[i].exp_n);

    // Reset while issuing, after two beats and one captured result.
    pkt_valid = 1'b1; pkt_data = 64'h0807_0605_0403_0201; pkt_len = 3'd4; op_ready = 1'b1;
    tick();
    pkt_valid = 1'b0;
    check("rs.beat0", op_data, 16'h0201);
    tick();
    check("rs.beat1", op_data, 16'h0403);
    res_valid = 1'b1; res_data = 8'd3;
    tick();
    res_valid = 1'b0;
    check("rs.partial", res_pkt, 32'h0000_0003);
    reset = 1'b1; op_ready = 1'b0;
    tick();
    reset = 1'b0;
    check("rs.op_valid", op_valid, 0);
    check("rs.res_pkt", res_pkt, 0);
    check("rs.pkt_ready", pkt_ready, 1);
    run_packet("after_rst", 64'h0109_0109_0109_0109, 4, 0, 1, 32'h0A0A_0A0A, 4);

    // Spurious result while idle.
    res_valid = 1'b1; res_data = 8'hAA;
    tick();
    res_valid = 1'b0;
    check("spur.ovf", res_ovf, 1);
    check("spur.res_pkt", res_pkt, 32'h0A0A_0A0A);
    tick();
    check("spur.sticky", res_ovf, 1);
    run_packet("spur_next", 64'h0807_0605_0403_0201, 4, 0, 1, 32'h0F0B_0703, 4);

    for (int i = 0; i < 10; i++) begin
      rd = {$urandom, $urandom};
      rl = $urandom_range(0, 7);
      run_packet($sformatf("rnd%0d", i), rd, rl, 2, $urandom_range(1, 6),
                 model_res(rd, rl), eff_len(rl));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
